multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multicycle RV32I core. It sits directly upstream of the datapath and drives every
//  enable and mux select there. It consumes op_out/func3/func7/zero/sign back from the datapath.
//  Supported instructions: R (add,sub,and,or,xor,slt), I-ALU (addi,andi,ori,xori,slti), lw, sw,
//  B (beq,bne,blt,bge), jal, jalr, lui.
// PARAMETERS
//  STATE_W     4  width of state register (holds 14 states)
//  ALU_CTRL_W  3  width of alu_control
// PORTS
//  clk          in   1  clock; all state updates on posedge
//  rst          in   1  synchronous, active-high reset
//  op           in   7  instr[6:0] from instruction register
//  func3        in   3  instr[14:12]
//  func7        in   7  instr[31:25]
//  zero         in   1  ALU result == 0
//  sign         in   1  ALU result[31]
//  mem_write    out  1  data memory write strobe
//  reg_write    out  1  register file write enable
//  pc_write     out  1  PC register load
//  ir_write     out  1  instruction register (and old_pc register) load
//  wd_sel       out  1  reg write data: 0=result, 1=pc_out (link address)
//  adr_src      out  1  memory address: 0=pc_out, 1=result
//  alu_src_a    out  2  00=pc_out 01=old_pc 10=rs1 reg 11=0
//  alu_src_b    out  2  00=rs2 reg 01=imm_ext 10=4 11=0
//  alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR
//  result_src   out  2  00=alu_out 01=data reg 10=alu_result 11=imm_ext
//  illegal      out  1  sticky illegal-opcode flag (tied 0 unless CTRL_ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  - Moore FSM; outputs decode from state, except pc_write in BRANCH, which also depends on zero/sign.
//  - Any output not listed for a state below is 0.
//  - rst=1: state<=FETCH and illegal<=0 at the edge. While rst is high all outputs are forced to 0, so no write
//    is issued. This holds even in mid-instruction; the partial instruction is abandoned.
//  - FETCH: adr_src=0, ir_write=1, a=00, b=10, ADD, result_src=10, pc_write=1 -> DECODE.
//  - DECODE: a=01, b=01, ADD (alu_out<=old_pc+imm).
//    Next state by op: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->MEM_ADR, 1100011->BRANCH,
//    1101111->JAL, 1100111->JALR, 0110111->LUI, other->ILLEGAL.
//  - EXEC_R: a=10, b=00, alu_control from alu_decoder -> ALU_WB.
//  - EXEC_I: a=10, b=01, alu_control from alu_decoder -> ALU_WB.
//  - ALU_WB: result_src=00, reg_write=1 -> FETCH.
//  - MEM_ADR: a=10, b=01, ADD -> MEM_READ if op=lw, MEM_WRITE if op=sw.
//  - MEM_READ: adr_src=1, result_src=00 -> MEM_WB.
//  - MEM_WB: result_src=01, reg_write=1 -> FETCH.
//  - MEM_WRITE: adr_src=1, result_src=00, mem_write=1 -> FETCH.
//  - BRANCH: a=10, b=00, SUB, result_src=00 -> FETCH.
//    pc_write: func3 000 = zero, 001 = ~zero, 100 = sign, 101 = ~sign, other = 0.
//  - JAL: result_src=00, pc_write=1, reg_write=1, wd_sel=1 -> FETCH.
//  - JALR: a=10, b=01, ADD, result_src=10, pc_write=1, reg_write=1, wd_sel=1 -> FETCH.
//  - LUI: result_src=11, reg_write=1, wd_sel=0 -> FETCH.
//  - Latency, counting FETCH: R/I=4, lw=5, sw=4, branch/jal/jalr/lui=3 cycles.
//  - ALU decode, R-type: f3 000 -> SUB if f7[5]=1 else ADD; 111 AND; 110 OR; 100 XOR; 010 SLT; other ADD.
//  - ALU decode, I-type: same table, but f3 000 is always ADD (func7 ignored).
//  - Decode takes op/func3/func7 live from the IR; the IR is stable after FETCH, so no latching is needed here.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined:
//    - ILLEGAL state sets illegal<=1 and holds there, all outputs 0, until rst.
//  CTRL_ILLEGAL_TRAP_EN undefined:
//    - ILLEGAL acts as a NOP (outputs 0) and goes -> FETCH next cycle.
//    - illegal stays 0.
// STRUCTURE
//  - Package ctrl_pkg: opcode constants, state encodings, ALU_ADD..ALU_XOR codes, SRCA_/SRCB_/RES_ select codes.
//  - One sub-module, alu_decoder (op, func3, func7 -> alu_control), instantiated in the EXEC states.
//  - Everything else (state register, next-state logic, output decode) lives in this module.
// TESTING
//  - Reset: hold rst 3 cycles mid-MEM_WRITE
//    -> mem_write=0 during rst; FETCH outputs (ir_write=1, pc_write=1) on the 1st cycle after release.
//  - lw x5,8(x1) (op 0000011)
//    -> states FETCH,DECODE,MEM_ADR,MEM_READ,MEM_WB; reg_write=1 only in cycle 5 with result_src=01.
//  - sub (op 0110011, f3 000, f7 0100000) -> alu_control=001 in EXEC_R.
//    addi with func7 bits = 0100000 -> alu_control=000.
//  - beq (f3 000): zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0.
//    bge (f3 101) with sign=1 -> pc_write=0.
//  - jal (op 1101111) -> 3 cycles; JAL state: pc_write=1, reg_write=1, wd_sel=1, result_src=00.
//  - op 0000000
//    -> macro defined: illegal=1 sticky, FSM frozen, no write strobes.
//    -> macro undefined: back to FETCH after 1 cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// ALU operation codes and datapath mux select codes.
package ctrl_pkg;

    localparam int CTRL_STATE_W = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_ILLEGAL
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU_RES = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps func3/func7 to an ALU operation for R-type and I-type ALU instructions.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [2:0] alu_control
);

    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        alu_control = ALU_ADD;
        case (func3)
            // Only R-type uses func7[5] to select SUB; addi ignores it.
            3'b000:  alu_control = (op == OP_R && func7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_control = ALU_AND;
            3'b110:  alu_control = ALU_OR;
            3'b100:  alu_control = ALU_XOR;
            3'b010:  alu_control = ALU_SLT;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main Moore control FSM of the multicycle RV32I core.
// Optional: CTRL_ILLEGAL_TRAP_EN makes an illegal opcode a sticky, frozen trap.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int STATE_W    = CTRL_STATE_W,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic                  zero,
    input  logic                  sign,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  wd_sel,
    output logic                  adr_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            result_src,
    output logic                  illegal
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [2:0]         alu_dec;
    logic [2:0]         alu_sel;
    logic               br_taken;

    alu_decoder u_alu_decoder (
        .op          (op),
        .func3       (func3),
        .func7       (func7),
        .alu_control (alu_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | (state_q == S_ILLEGAL);

    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_R:          state_d = S_EXEC_R;
                    OP_I:          state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADR;
                    OP_BR:         state_d = S_BRANCH;
                    OP_JAL:        state_d = S_JAL;
                    OP_JALR:       state_d = S_JALR;
                    OP_LUI:        state_d = S_LUI;
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADR:          state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:         state_d = S_MEM_WB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL:          state_d = S_ILLEGAL;
`else
            S_ILLEGAL:          state_d = S_FETCH;
`endif
            default:            state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (func3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = sign;
            3'b101:  br_taken = ~sign;
            default: br_taken = 1'b0;
        endcase
    end

    // Reset forces every strobe low, even if the FSM was mid-instruction.
    always_comb begin
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        wd_sel     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_sel    = ALU_ADD;
        result_src = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU_RES;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLD_PC;
                    alu_src_b = SRCB_IMM;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_sel   = alu_dec;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_sel   = alu_dec;
                end
                S_ALU_WB: begin
                    result_src = RES_ALU_OUT;
                    reg_write  = 1'b1;
                end
                S_MEM_ADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_READ: begin
                    adr_src    = 1'b1;
                    result_src = RES_ALU_OUT;
                end
                S_MEM_WB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEM_WRITE: begin
                    adr_src    = 1'b1;
                    result_src = RES_ALU_OUT;
                    mem_write  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_sel    = ALU_SUB;
                    result_src = RES_ALU_OUT;
                    pc_write   = br_taken;
                end
                S_JAL: begin
                    result_src = RES_ALU_OUT;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    wd_sel     = 1'b1;
                end
                S_JALR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    result_src = RES_ALU_RES;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    wd_sel     = 1'b1;
                end
                S_LUI: begin
                    result_src = RES_IMM;
                    reg_write  = 1'b1;
                end
                default: ;
            endcase
        end
        alu_control = ALU_CTRL_W'(alu_sel);
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal = illegal_q & ~rst;
`else
        illegal = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller with a per-instruction-class step model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero, sign;
    logic       mem_write, reg_write, pc_write, ir_write, wd_sel, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_ILL = 8;

    logic [6:0] op_tab [0:7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .sign(sign),
        .mem_write(mem_write), .reg_write(reg_write), .pc_write(pc_write),
        .ir_write(ir_write), .wd_sel(wd_sel), .adr_src(adr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .result_src(result_src), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {mem_write, reg_write, pc_write, ir_write, wd_sel, adr_src,
                  alu_src_a, alu_src_b, alu_control, result_src, illegal};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input logic mw, input logic rw, input logic pw,
                                       input logic irw, input logic wd, input logic adr,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [1:0] res,
                                       input logic ill);
        return {mw, rw, pw, irw, wd, adr, a, b, alu, res, ill};
    endfunction

    function automatic int kind_of(input logic [6:0] o);
        for (int k = 0; k < 8; k++)
            if (op_tab[k] == o) return k;
        return K_ILL;
    endfunction

    function automatic int len_of(input int k);
        if (k == K_LW) return 5;
        if (k == K_R || k == K_I || k == K_SW) return 4;
        return 3;
    endfunction

    function automatic logic [2:0] alu_ref(input bit is_r, input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return (is_r && f7[5]) ? 3'b001 : 3'b000;
            3'd7:    return 3'b010;
            3'd6:    return 3'b011;
            3'd4:    return 3'b101;
            3'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] expect_out(input int k, input int step, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic z, input logic s);
        logic taken;
        taken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? s : (f3 == 3'd5) ? !s : 1'b0;
        if (step == 0) return pk(0,0,1,1,0,0, 2'b00,2'b10,3'b000,2'b10,0);
        if (step == 1) return pk(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b00,0);
        if (step == 2) begin
            case (k)
                K_R:          return pk(0,0,0,0,0,0, 2'b10,2'b00,alu_ref(1,f3,f7),2'b00,0);
                K_I:          return pk(0,0,0,0,0,0, 2'b10,2'b01,alu_ref(0,f3,f7),2'b00,0);
                K_LW, K_SW:   return pk(0,0,0,0,0,0, 2'b10,2'b01,3'b000,2'b00,0);
                K_BR:         return pk(0,0,taken,0,0,0, 2'b10,2'b00,3'b001,2'b00,0);
                K_JAL:        return pk(0,1,1,0,1,0, 2'b00,2'b00,3'b000,2'b00,0);
                K_JALR:       return pk(0,1,1,0,1,0, 2'b10,2'b01,3'b000,2'b10,0);
                K_LUI:        return pk(0,1,0,0,0,0, 2'b00,2'b00,3'b000,2'b11,0);
                default:      return 16'h0000;
            endcase
        end
        if (step == 3) begin
            case (k)
                K_R, K_I: return pk(0,1,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,0);
                K_LW:     return pk(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,0);
                K_SW:     return pk(1,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,0);
                default:  return 16'h0000;
            endcase
        end
        return pk(0,1,0,0,0,0, 2'b00,2'b00,3'b000,2'b01,0);
    endfunction

    // Called at a falling edge with the FSM in FETCH; returns at the falling edge of the next FETCH.
    // zs < 0 randomizes zero/sign each cycle; abort_at >= 0 applies a 3-cycle reset after that step.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                             input int zs, input int abort_at);
        int k;
        logic [31:0] r;
        k = kind_of(o);
        op = o; func3 = f3; func7 = f7;
        for (int step = 0; step < len_of(k); step++) begin
            r = $urandom;
            if (zs < 0) begin zero = r[0]; sign = r[1]; end
            else begin zero = zs[1]; sign = zs[0]; end
            #1;
            check_eq($sformatf("op%b_f3%b_step%0d", o, f3, step), obs,
                     expect_out(k, step, f3, f7, zero, sign));
            if (step == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq("rst_mid_mem_write", {15'b0, mem_write}, 16'h0000);
                check_eq("rst_mid_all", obs, 16'h0000);
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk); #1;
                    check_eq("rst_hold", obs, 16'h0000);
                end
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  rop;
        int          rk;
        rst = 1'b1; op = 7'b0; func3 = 3'b0; func7 = 7'b0; zero = 1'b0; sign = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check_eq("reset_state", obs, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;

        run_instr(7'b0000011, 3'b010, 7'b0000000, -1, -1);   // lw x5,8(x1)
        run_instr(7'b0110011, 3'b000, 7'b0100000, -1, -1);   // sub
        run_instr(7'b0010011, 3'b000, 7'b0100000, -1, -1);   // addi, func7 ignored
        run_instr(7'b1100011, 3'b000, 7'b0000000, 2, -1);    // beq taken
        run_instr(7'b1100011, 3'b000, 7'b0000000, 0, -1);    // beq not taken
        run_instr(7'b1100011, 3'b101, 7'b0000000, 1, -1);    // bge, sign=1
        run_instr(7'b1101111, 3'b011, 7'b1010101, -1, -1);   // jal
        run_instr(7'b0100011, 3'b010, 7'b0000000, -1, 3);    // sw, reset in MEM_WRITE
`ifndef CTRL_ILLEGAL_TRAP_EN
        run_instr(7'b0000000, 3'b000, 7'b0000000, -1, -1);   // illegal acts as NOP
`endif

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
`ifdef CTRL_ILLEGAL_TRAP_EN
            rk = int'(r[31:28]) % 8;
`else
            rk = int'(r[31:28]) % 9;
`endif
            if (rk == K_ILL) begin
                rop = r[6:0];
                while (kind_of(rop) != K_ILL) rop = rop + 7'd1;
            end else begin
                rop = op_tab[rk];
            end
            run_instr(rop, r[9:7], r[16:10], -1, -1);
        end
        #1;
        check_eq("final_fetch", obs, expect_out(K_R, 0, 3'b0, 7'b0, 1'b0, 1'b0));

`ifdef CTRL_ILLEGAL_TRAP_EN
        @(negedge clk);   // DECODE of the pending op: drive the illegal op from FETCH instead
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op = 7'b0000000; func3 = 3'b0; func7 = 7'b0;
        for (int step = 0; step < 3; step++) begin
            #1;
            check_eq($sformatf("trap_step%0d", step), obs,
                     expect_out(K_ILL, step, 3'b0, 7'b0, zero, sign));
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("trap_frozen", obs, 16'h0001);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check_eq("trap_rst_out", obs, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("trap_cleared_fetch", obs, expect_out(K_R, 0, 3'b0, 7'b0, 1'b0, 1'b0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
